gate_interlock: RTL and testbench

//  Downstream of the load-commutation FSM: consumes its 6-bit switch command (Sout) and drives the
//  six device gates. Per-device turn-on delay (dead time); turn-off is immediate. Blocks any

---
 rtl/gate_interlock.sv | 106 ++++++++++
 tb/tb_gate_interlock.sv | 127 ++++++++++++
 2 files changed

// File: rtl/gate_interlock.sv
// rtl/gate_interlock.sv - six-gate drive with per-device turn-on delay, pattern check and latched fault
module gate_interlock #(
  parameter int DEAD = 3,
  parameter int CW   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Sin,
  input  logic       short_in,
  input  logic       fault_clr,
  output logic [5:0] Gout,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] fault_cnt
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

  state_t        state_q, state_d;
  logic [5:0]    gout_q, gout_d;
  logic [CW-1:0] cnt_q [6];
  logic [CW-1:0] cnt_d [6];
  logic [1:0]    code_q, code_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          short_s;
  logic [2:0]    ones;
  logic          illegal;

  assign short_s = sync2_q;

  always_comb begin
    ones = 3'd0;
    for (int i = 0; i < 6; i++) ones = ones + {2'b00, Sin[i]};
    illegal = (ones > 3'd2);
  end

  always_comb begin
    state_d = state_q;
    gout_d  = gout_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    fcnt_d  = fcnt_q;
    sync1_d = short_in;
    sync2_d = sync1_q;
    case (state_q)
      RUN: begin
        if (illegal || short_s) begin
          // Fault wins over any gating change on this edge: the bad pattern never reaches Gout.
          state_d = FAULT;
          gout_d  = 6'b0;
          for (int i = 0; i < 6; i++) cnt_d[i] = '0;
          code_d  = {short_s, illegal};
          if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
        end else begin
          for (int i = 0; i < 6; i++) begin
            if (!Sin[i]) begin
              cnt_d[i]  = '0;
              gout_d[i] = 1'b0;
            end else if (cnt_q[i] < DEAD_C) begin
              cnt_d[i]  = cnt_q[i] + 1'b1;
              gout_d[i] = 1'b0;
            end else begin
              gout_d[i] = 1'b1;
            end
          end
        end
      end
      FAULT: begin
        gout_d = 6'b0;
        for (int i = 0; i < 6; i++) cnt_d[i] = '0;
        if (fault_clr && (Sin == 6'b0) && !short_s) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      gout_q  <= 6'b0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      code_q  <= 2'b00;
      fcnt_q  <= 8'd0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gout_q  <= gout_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
      code_q  <= code_d;
      fcnt_q  <= fcnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign Gout       = gout_q;
  assign fault      = (state_q == FAULT);
  assign fault_code = code_q;
  assign fault_cnt  = fcnt_q;

endmodule

// File: tb/tb_gate_interlock.sv
// tb/tb_gate_interlock.sv - directed bench for gate_interlock with DEAD=3
module tb_gate_interlock;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Sin;
  logic       short_in;
  logic       fault_clr;
  logic [5:0] Gout;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] fault_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  gate_interlock #(.DEAD(3), .CW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .Sin        (Sin),
    .short_in   (short_in),
    .fault_clr  (fault_clr),
    .Gout       (Gout),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_cnt  (fault_cnt)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [5:0] g, input logic f,
                           input logic [1:0] c, input logic [7:0] n);
    check({tag, ".gout"}, {2'b00, Gout}, {2'b00, g});
    check({tag, ".fault"}, {7'd0, fault}, {7'd0, f});
    check({tag, ".code"}, {6'd0, fault_code}, {6'd0, c});
    check({tag, ".cnt"}, fault_cnt, n);
  endtask

  initial begin
    rst = 1'b1; Sin = 6'b110000; short_in = 1'b0; fault_clr = 1'b0;
    #1;
    tick(); tick();
    check_all("reset", 6'b0, 1'b0, 2'b00, 8'd0);

    // Turn-on delay: DEAD+1 edges
    rst = 1'b0;
    tick(); check_all("dly_k0", 6'b0, 1'b0, 2'b00, 8'd0);
    tick(); check_all("dly_k1", 6'b0, 1'b0, 2'b00, 8'd0);
    tick(); check_all("dly_k2", 6'b0, 1'b0, 2'b00, 8'd0);
    tick(); check_all("dly_k3", 6'b110000, 1'b0, 2'b00, 8'd0);

    // Legal commutation; fault_clr in RUN is harmless
    Sin = 6'b100000; fault_clr = 1'b1;
    tick(); check_all("comm_a0", 6'b100000, 1'b0, 2'b00, 8'd0);
    tick(); check_all("comm_a1", 6'b100000, 1'b0, 2'b00, 8'd0);
    Sin = 6'b101000; fault_clr = 1'b0;
    tick(); check_all("comm_b0", 6'b100000, 1'b0, 2'b00, 8'd0);
    tick(); check_all("comm_b1", 6'b100000, 1'b0, 2'b00, 8'd0);

    // Illegal pattern
    Sin = 6'b111000;
    tick(); check_all("illegal", 6'b0, 1'b1, 2'b01, 8'd1);
    fault_clr = 1'b1;
    tick(); check_all("clr_blocked", 6'b0, 1'b1, 2'b01, 8'd1);

    // Clear and restart delay from zero
    Sin = 6'b000000;
    tick(); check_all("clr_ok", 6'b0, 1'b0, 2'b01, 8'd1);
    fault_clr = 1'b0; Sin = 6'b001100;
    tick(); check_all("rerun0", 6'b0, 1'b0, 2'b01, 8'd1);
    tick(); check_all("rerun1", 6'b0, 1'b0, 2'b01, 8'd1);
    tick(); check_all("rerun2", 6'b0, 1'b0, 2'b01, 8'd1);
    tick(); check_all("rerun3", 6'b001100, 1'b0, 2'b01, 8'd1);

    // Short pulse through the synchronizer
    short_in = 1'b1;
    tick(); check_all("short_e0", 6'b001100, 1'b0, 2'b01, 8'd1);
    short_in = 1'b0;
    tick(); check_all("short_e1", 6'b001100, 1'b0, 2'b01, 8'd1);
    tick(); check_all("short_e2", 6'b0, 1'b1, 2'b10, 8'd2);
    Sin = 6'b111111;
    tick(); check_all("fault_hold", 6'b0, 1'b1, 2'b10, 8'd2);

    // Reset mid-fault
    rst = 1'b1;
    tick(); check_all("rst_fault", 6'b0, 1'b0, 2'b00, 8'd0);
    rst = 1'b0; Sin = 6'b000000;
    tick();

    // Short and illegal on the same edge
    short_in = 1'b1;
    tick();
    short_in = 1'b0;
    tick(); check_all("both_pre", 6'b0, 1'b0, 2'b00, 8'd0);
    Sin = 6'b111000;
    tick(); check_all("both", 6'b0, 1'b1, 2'b11, 8'd1);

    // Saturation of the fault counter
    for (int i = 0; i < 260; i++) begin
      Sin = 6'b000000; fault_clr = 1'b1;
      tick();
      Sin = 6'b010101; fault_clr = 1'b0;
      tick();
    end
    check("sat.cnt", fault_cnt, 8'd255);
    check("sat.fault", {7'd0, fault}, 8'd1);
    check("sat.code", {6'd0, fault_code}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
